morse_message_sequencer: RTL and testbench

MORSE_MESSAGE_SEQUENCER -- requirements
Module: morse_message_sequencer

---
 rtl/morse_message_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_morse_message_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_message_sequencer.sv
// -----------------------------------------------------------------------------
// morse_message_sequencer
//
// Queues up to four 3-bit letter codes (A..H) and plays each one out as a
// 12-bit Morse pattern, MSB first. Each pattern bit is held for TICK_LEN
// clock cycles. After each letter, GAP_TICKS ticks of zeros follow.
//
// Ports
//   ClockIn      in   sole clock, rising edge
//   Reset        in   asynchronous, active-high
//   LetterValid  in   producer offers Letter this cycle
//   Letter       in   [2:0] letter code, 0..7 = A..H
//   LetterReady  out  queue can accept (FifoCount < 4)
//   Abort        in   synchronous flush of the queue and of the current letter
//   DotDashOut   out  registered Morse level
//   NewBitOut    out  one-cycle pulse on the first cycle of each new symbol
//   Busy         out  high whenever the FSM is not IDLE
//   FifoCount    out  [2:0] number of queued letters, 0..4
//   Done         out  one-cycle pulse when the queue drains back to IDLE
//   StateDebug   out  [1:0] current FSM state, for observation only
//
// Handshake: a letter transfers on a rising edge where LetterValid=1,
// LetterReady=1 and Abort=0. LetterReady depends only on registered state,
// so the producer may hold LetterValid and Letter stable until it sees the
// transfer. An offer while full is ignored.
// -----------------------------------------------------------------------------
module morse_message_sequencer #(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int GAP_TICKS       = 2
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       LetterValid,
  input  logic [2:0] Letter,
  output logic       LetterReady,
  input  logic       Abort,
  output logic       DotDashOut,
  output logic       NewBitOut,
  output logic       Busy,
  output logic [2:0] FifoCount,
  output logic       Done,
  output logic [1:0] StateDebug
);

  localparam int FIFO_DEPTH = 4;
  localparam int TICK_LEN   = CLOCK_FREQUENCY / 2;
  localparam int TICK_W     = $clog2(CLOCK_FREQUENCY);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_LEN - 1);
  // In GAP the bit counter is reused to count gap ticks.
  localparam logic [3:0] GAP_LAST = (GAP_TICKS > 0) ? 4'(GAP_TICKS - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  fifo_q [FIFO_DEPTH];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [11:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic        dot_q, dot_d;
  logic        new_bit_q, new_bit_d;
  logic        done_q, done_d;

  logic        push;
  logic        pop;
  logic        tick;

  function automatic logic [11:0] pattern_of(input logic [2:0] code);
    case (code)
      3'd0:    pattern_of = 12'b1011_1000_0000; // A
      3'd1:    pattern_of = 12'b1110_1010_1000; // B
      3'd2:    pattern_of = 12'b1110_1011_1010; // C
      3'd3:    pattern_of = 12'b1110_1010_0000; // D
      3'd4:    pattern_of = 12'b1000_0000_0000; // E
      3'd5:    pattern_of = 12'b1010_1110_1000; // F
      3'd6:    pattern_of = 12'b1110_1110_1000; // G
      default: pattern_of = 12'b1010_1010_0000; // H
    endcase
  endfunction

  assign LetterReady = (count_q < 3'(FIFO_DEPTH));
  assign push        = LetterValid && LetterReady && !Abort;
  assign tick        = (tick_cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    tick_cnt_d = tick_cnt_q;
    dot_d      = 1'b0;
    new_bit_d  = 1'b0;
    done_d     = 1'b0;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != 3'd0) state_d = S_LOAD;
      end
      S_LOAD: begin
        pop        = 1'b1;
        shift_d    = pattern_of(fifo_q[rd_ptr_q]);
        bit_cnt_d  = 4'd0;
        tick_cnt_d = TICK_LAST;
        new_bit_d  = 1'b1;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (tick) begin
          tick_cnt_d = TICK_LAST;
          shift_d    = {shift_q[10:0], 1'b0};
          if (bit_cnt_q == 4'd11) begin
            bit_cnt_d = 4'd0;
            if (GAP_TICKS > 0) begin
              state_d = S_GAP;
            end else if (count_q != 3'd0) begin
              state_d = S_LOAD;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            new_bit_d = 1'b1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (tick) begin
          tick_cnt_d = TICK_LAST;
          if (bit_cnt_q == GAP_LAST) begin
            bit_cnt_d = 4'd0;
            if (count_q != 3'd0) begin
              state_d = S_LOAD;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          tick_cnt_d = tick_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Queue bookkeeping; simultaneous push and pop leave the count unchanged.
    if (push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
    if (push && !pop)      count_d = count_q + 3'd1;
    else if (!push && pop) count_d = count_q - 3'd1;

    // Output level follows the MSB of the register being shifted out.
    dot_d = (state_d == S_SEND) ? shift_d[11] : 1'b0;

    // Abort wins over everything, including a same-cycle push.
    if (Abort) begin
      state_d    = S_IDLE;
      wr_ptr_d   = 2'd0;
      rd_ptr_d   = 2'd0;
      count_d    = 3'd0;
      shift_d    = 12'd0;
      bit_cnt_d  = 4'd0;
      tick_cnt_d = '0;
      dot_d      = 1'b0;
      new_bit_d  = 1'b0;
      done_d     = 1'b0;
    end
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      shift_q    <= 12'd0;
      bit_cnt_q  <= 4'd0;
      tick_cnt_q <= '0;
      dot_q      <= 1'b0;
      new_bit_q  <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= 3'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      dot_q      <= dot_d;
      new_bit_q  <= new_bit_d;
      done_q     <= done_d;
      if (push) fifo_q[wr_ptr_q] <= Letter;
    end
  end

  assign DotDashOut = dot_q;
  assign NewBitOut  = new_bit_q;
  assign Done       = done_q;
  assign Busy       = (state_q != S_IDLE);
  assign FifoCount  = count_q;
  assign StateDebug = state_q;

endmodule

// File: tb/tb_morse_message_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for morse_message_sequencer. Two instances share all stimulus:
// dut (GAP_TICKS=2) and dut0 (GAP_TICKS=0), both with TICK_LEN=4.
// A reference model tracks each instance as a letter queue plus a position
// in the per-letter timeline (LOAD, 48 send cycles, gap cycles).
// -----------------------------------------------------------------------------
module tb_morse_message_sequencer;

  localparam int CF = 8;
  localparam int T  = CF / 2;
  localparam logic [11:0] PAT [8] = '{
    12'b101110000000, 12'b111010101000, 12'b111010111010, 12'b111010100000,
    12'b100000000000, 12'b101011101000, 12'b111011101000, 12'b101010100000
  };

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       valid = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] letter = 3'd0;

  logic       rdy0, dot0, nb0, busy0, done0;
  logic [2:0] cnt0;
  logic [1:0] st0;
  logic       rdy1, dot1, nb1, busy1, done1;
  logic [2:0] cnt1;
  logic [1:0] st1;

  morse_message_sequencer #(.CLOCK_FREQUENCY(CF), .GAP_TICKS(2)) dut (
    .ClockIn(clk), .Reset(rst), .LetterValid(valid), .Letter(letter),
    .LetterReady(rdy0), .Abort(abort), .DotDashOut(dot0), .NewBitOut(nb0),
    .Busy(busy0), .FifoCount(cnt0), .Done(done0), .StateDebug(st0)
  );

  morse_message_sequencer #(.CLOCK_FREQUENCY(CF), .GAP_TICKS(0)) dut0 (
    .ClockIn(clk), .Reset(rst), .LetterValid(valid), .Letter(letter),
    .LetterReady(rdy1), .Abort(abort), .DotDashOut(dot1), .NewBitOut(nb1),
    .Busy(busy1), .FifoCount(cnt1), .Done(done1), .StateDebug(st1)
  );

  int checks = 0;
  int errors = 0;

  // reference model: pos -1 = idle, 0 = load, 1..48 = send, then gap cycles
  logic [2:0]  mq   [2][4];
  int          msz  [2] = '{0, 0};
  int          mpos [2] = '{-1, -1};
  logic [11:0] mpat [2] = '{12'd0, 12'd0};
  logic        mdone[2] = '{1'b0, 1'b0};
  int          m_last;
  int          m_sz0;
  bit          m_push;

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || abort) begin
        msz[i] = 0; mpos[i] = -1; mdone[i] = 1'b0; mpat[i] = 12'd0;
      end else begin
        m_last   = 12 * T + ((i == 0) ? 2 : 0) * T;
        m_sz0    = msz[i];
        m_push   = valid && (m_sz0 < 4);
        mdone[i] = 1'b0;
        if (mpos[i] == -1) begin
          if (m_sz0 > 0) mpos[i] = 0;
        end else if (mpos[i] == 0) begin
          mpat[i] = PAT[mq[i][0]];
          for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
          msz[i]  = msz[i] - 1;
          mpos[i] = 1;
        end else if (mpos[i] == m_last) begin
          if (m_sz0 > 0) mpos[i] = 0;
          else begin mpos[i] = -1; mdone[i] = 1'b1; end
        end else begin
          mpos[i] = mpos[i] + 1;
        end
        if (m_push) begin
          mq[i][msz[i]] = letter;
          msz[i] = msz[i] + 1;
        end
      end
    end
  end

  // {ready, count, busy, dot, newbit, done}
  function automatic logic [7:0] exp_vec(input int i);
    logic d, n;
    int   p;
    p = mpos[i];
    d = 1'b0;
    n = 1'b0;
    if (p >= 1 && p <= 12 * T) begin
      d = mpat[i][11 - (p - 1) / T];
      n = ((p - 1) % T) == 0;
    end
    return {msz[i] < 4, 3'(msz[i]), p != -1, d, n, mdone[i]};
  endfunction

  function automatic logic [7:0] obs_of(input int i);
    if (i == 0) return {rdy0, cnt0, busy0, dot0, nb0, done0};
    return {rdy1, cnt1, busy1, dot1, nb1, done1};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget, output int dones0);
    int c;
    c = 0;
    dones0 = 0;
    while ((busy0 || busy1 || cnt0 != 3'd0 || cnt1 != 3'd0) && c < budget) begin
      cyc();
      c++;
      if (done0) dones0++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL %s_cycle inst%0d t=%0t got %b expected %b", tag, i, $time, obs_of(i), exp_vec(i));
        end
      end
    end
    checks++;
    if (c >= budget) begin
      errors++;
      $display("FAIL %s_drain_timeout states %0d/%0d got busy still high, expected idle within %0d cycles", tag, st0, st1, budget);
    end
  endtask

  task automatic test_reset();
    repeat (3) cyc();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_of(i) !== 8'b1000_0000) begin
        errors++;
        $display("FAIL reset_state inst%0d got %b expected %b", i, obs_of(i), 8'b1000_0000);
      end
    end
    #2 rst = 1'b0;
    repeat (3) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL reset_release inst%0d got %b expected %b", i, obs_of(i), exp_vec(i));
        end
      end
    end
  endtask

  task automatic test_single_e();
    int nb_cnt, dot_cnt, first_nb, done_at, done_n;
    nb_cnt = 0; dot_cnt = 0; first_nb = -1; done_at = -1; done_n = 0;
    valid = 1'b1; letter = 3'd4;
    for (int c = 0; c < 80; c++) begin
      cyc();
      valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL single_e_cycle inst%0d c=%0d got %b expected %b", i, c, obs_of(i), exp_vec(i));
        end
      end
      if (nb0) begin nb_cnt++; if (first_nb < 0) first_nb = c; end
      if (dot0) dot_cnt++;
      if (done0) begin done_n++; done_at = c; end
    end
    checks++;
    if (nb_cnt != 12) begin errors++; $display("FAIL single_e_newbits got %0d expected 12", nb_cnt); end
    checks++;
    if (dot_cnt != T) begin errors++; $display("FAIL single_e_dot_cycles got %0d expected %0d", dot_cnt, T); end
    checks++;
    if (first_nb != 2) begin errors++; $display("FAIL single_e_first_bit got %0d expected 2", first_nb); end
    checks++;
    if (done_at != 58 || done_n != 1) begin
      errors++;
      $display("FAIL single_e_done got cycle %0d count %0d expected cycle 58 count 1", done_at, done_n);
    end
  endtask

  task automatic test_back_to_back();
    bit ready_dropped;
    int dones;
    ready_dropped = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1; letter = 3'(k);
      if (!rdy0) ready_dropped = 1'b1;
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL b2b_push inst%0d k=%0d got %b expected %b", i, k, obs_of(i), exp_vec(i));
        end
      end
    end
    valid = 1'b0;
    if (!rdy0) ready_dropped = 1'b1;
    checks++;
    if (cnt0 !== 3'd3) begin errors++; $display("FAIL b2b_count got %0d expected 3", cnt0); end
    checks++;
    if (ready_dropped) begin errors++; $display("FAIL b2b_ready got 0 expected 1 throughout"); end
    repeat (20) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL b2b_cycle inst%0d got %b expected %b", i, obs_of(i), exp_vec(i));
        end
      end
    end
    valid = 1'b1; letter = 3'($urandom_range(4, 7));
    cyc();
    valid = 1'b0;
    drain("b2b", 600, dones);
    checks++;
    if (dones != 1) begin errors++; $display("FAIL b2b_done_count got %0d expected 1", dones); end
  endtask

  task automatic test_full_hold();
    logic [2:0] seq [6];
    int idx, c, h_cnt, dones;
    bit saw_block, acc;
    seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    idx = 0; c = 0; h_cnt = -1; saw_block = 1'b0;
    while (idx < 6 && c < 400) begin
      valid = 1'b1; letter = seq[idx];
      acc = rdy0;
      cyc();
      c++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL full_cycle inst%0d c=%0d got %b expected %b", i, c, obs_of(i), exp_vec(i));
        end
      end
      if (idx == 5 && !acc) saw_block = 1'b1;
      if (acc) begin
        if (idx == 5) h_cnt = cnt0;
        idx++;
      end
    end
    valid = 1'b0;
    checks++;
    if (idx != 6) begin errors++; $display("FAIL full_accept got %0d letters expected 6", idx); end
    checks++;
    if (!saw_block) begin errors++; $display("FAIL full_ready got never low expected low while full"); end
    checks++;
    if (h_cnt != 4) begin errors++; $display("FAIL full_count_after_h got %0d expected 4", h_cnt); end
    drain("full", 700, dones);
  endtask

  task automatic test_abort();
    int nb_seen, c, activity, dones;
    nb_seen = 0; c = 0; activity = 0;
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1; letter = 3'(2 + k);
      cyc();
      if (nb0) nb_seen++;
    end
    valid = 1'b0;
    while (nb_seen < 6 && c < 100) begin
      cyc();
      c++;
      if (nb0) nb_seen++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL abort_cycle inst%0d got %b expected %b", i, obs_of(i), exp_vec(i));
        end
      end
    end
    cyc();
    checks++;
    if (cnt0 !== 3'd2) begin errors++; $display("FAIL abort_queued got %0d expected 2", cnt0); end
    abort = 1'b1; valid = 1'b1; letter = 3'd5;
    cyc();
    abort = 1'b0; valid = 1'b0;
    checks++;
    if ({busy0, cnt0, dot0, nb0, done0} !== 7'd0) begin
      errors++;
      $display("FAIL abort_flush got busy=%b cnt=%0d dot=%b nb=%b done=%b expected all 0", busy0, cnt0, dot0, nb0, done0);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_of(i) !== exp_vec(i)) begin
        errors++;
        $display("FAIL abort_next inst%0d got %b expected %b", i, obs_of(i), exp_vec(i));
      end
    end
    repeat (30) begin
      cyc();
      if (nb0 || done0 || busy0 || dot0) activity++;
    end
    checks++;
    if (activity != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles expected 0", activity); end
    drain("abort", 10, dones);
  endtask

  task automatic test_reset_mid();
    int activity, dones;
    activity = 0;
    valid = 1'b1; letter = 3'd6;
    cyc();
    valid = 1'b0;
    repeat (30) begin
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL rstmid_cycle inst%0d got %b expected %b", i, obs_of(i), exp_vec(i));
        end
      end
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_of(i) !== 8'b1000_0000) begin
        errors++;
        $display("FAIL rstmid_async inst%0d got %b expected %b", i, obs_of(i), 8'b1000_0000);
      end
    end
    repeat (2) cyc();
    #2 rst = 1'b0;
    repeat (100) begin
      cyc();
      if (obs_of(0) !== 8'b1000_0000 || obs_of(1) !== 8'b1000_0000) activity++;
    end
    checks++;
    if (activity != 0) begin errors++; $display("FAIL rstmid_idle got %0d changed cycles expected 0", activity); end
    drain("rstmid", 10, dones);
  endtask

  task automatic test_gap0();
    int nb_t[$];
    int c, dones;
    c = 0;
    valid = 1'b1; letter = 3'd5;
    cyc();
    letter = 3'd6;
    cyc();
    valid = 1'b0;
    while ((busy0 || busy1 || cnt0 != 3'd0 || cnt1 != 3'd0) && c < 300) begin
      cyc();
      c++;
      if (nb1) nb_t.push_back(c);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL gap0_cycle inst%0d got %b expected %b", i, obs_of(i), exp_vec(i));
        end
      end
    end
    checks++;
    if (nb_t.size() != 24) begin
      errors++;
      $display("FAIL gap0_newbits got %0d expected 24", nb_t.size());
    end else begin
      checks++;
      if (nb_t[12] - nb_t[11] != T + 1) begin
        errors++;
        $display("FAIL gap0_spacing got %0d expected %0d", nb_t[12] - nb_t[11], T + 1);
      end
    end
    drain("gap0", 10, dones);
  endtask

  task automatic test_random();
    int dones;
    for (int c = 0; c < 1500; c++) begin
      valid  = ($urandom_range(0, 2) == 0);
      letter = 3'($urandom_range(0, 7));
      abort  = ($urandom_range(0, 199) == 0);
      cyc();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_vec(i)) begin
          errors++;
          $display("FAIL random_cycle inst%0d c=%0d got %b expected %b", i, c, obs_of(i), exp_vec(i));
        end
      end
    end
    valid = 1'b0; abort = 1'b0;
    drain("random", 800, dones);
  endtask

  initial begin
    test_reset();
    test_single_e();
    test_back_to_back();
    test_full_hold();
    test_abort();
    test_reset_mid();
    test_gap0();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
